mem_port_arbiter: RTL

Shares one unified, variable-latency memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage pipeline. It arbitrates, sequences one transaction at a time with a req/ack handshake, and returns read data plus a one-cycle ready pulse. The pipeline stalls a stage while that stage's request is high and its ready is low.

---
 rtl/arb_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/arb_pick.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding, grant IDs and constants for mem_port_arbiter
package arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_DM = 3'd2,
    RESP_IF = 3'd3,
    RESP_DM = 3'd4
  } arb_state_e;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  localparam logic [31:0] TIMEOUT_FILL = 32'hDEADBEEF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, memory and status signals of the shared memory port
interface mem_port_arbiter_if;

  logic        start_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ready_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ready_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  modport slave (
    input  start_i, if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_ack_i, mem_rdata_i,
    output if_ready_o, if_rdata_o, dm_ready_o, dm_rdata_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );

  modport master (
    output start_i, if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_ack_i, mem_rdata_i,
    input  if_ready_o, if_rdata_o, dm_ready_o, dm_rdata_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );

endinterface

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - winner selection between IF and DM with a saturating IF-starvation counter
module arb_pick
  import arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arb_en,
  input  logic if_req,
  input  logic dm_req,
  output logic grant_valid,
  output logic grant_id
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  // DM is the older instruction and normally wins, until IF has waited out LIMIT DM grants.
  always_comb begin
    grant_valid = arb_en & (if_req | dm_req);
    grant_id    = GNT_IF;
    if (dm_req && !(if_req && starve_cnt == LIMIT)) begin
      grant_id = GNT_DM;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= 4'd0;
    end else if (grant_valid) begin
      if (grant_id == GNT_IF) begin
        starve_cnt <= 4'd0;
      end else if (if_req && starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter sequencing one req/ack transaction at a time on a shared memory port
// Optional ARB_TIMEOUT_EN: abort a transaction after TIMEOUT unacked cycles and raise sticky err_o.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 64
) (
  input logic              clk_i,
  input logic              rst_i,
  mem_port_arbiter_if.slave bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT < 1) begin : g_param_check
    $error("mem_port_arbiter: parameter out of range");
  end

  arb_state_e  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        grant_valid;
  logic        grant_id;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;
`endif

  arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .arb_en      (state_q == IDLE && bus.start_i),
    .if_req      (bus.if_req_i),
    .dm_req      (bus.dm_req_i),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
`ifdef ARB_TIMEOUT_EN
    tmo_d       = 16'd0;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          mem_req_d = 1'b1;
          if (grant_id == GNT_DM) begin
            mem_we_d    = bus.dm_we_i;
            mem_addr_d  = bus.dm_addr_i;
            mem_wdata_d = bus.dm_wdata_i;
            state_d     = BUSY_DM;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr_i;
            mem_wdata_d = 32'd0;
            state_d     = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (bus.mem_ack_i) begin
          mem_req_d = 1'b0;
          if (state_q == BUSY_IF) begin
            if_rdata_d = bus.mem_rdata_i;
            state_d    = RESP_IF;
          end else begin
            if (!mem_we_q) begin
              dm_rdata_d = bus.mem_rdata_i;
            end
            state_d = RESP_DM;
          end
        end
`ifdef ARB_TIMEOUT_EN
        // Fill the response with a marker so a hung memory never deadlocks the pipeline.
        else if (tmo_q == TMO_LAST) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == BUSY_IF) begin
            if_rdata_d = TIMEOUT_FILL;
            state_d    = RESP_IF;
          end else begin
            dm_rdata_d = TIMEOUT_FILL;
            state_d    = RESP_DM;
          end
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      RESP_IF, RESP_DM: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
`ifdef ARB_TIMEOUT_EN
      tmo_q       <= 16'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
`ifdef ARB_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.if_ready_o  = (state_q == RESP_IF);
  assign bus.dm_ready_o  = (state_q == RESP_DM);
`ifdef ARB_TIMEOUT_EN
  assign bus.err_o       = err_q;
`else
  assign bus.err_o       = 1'b0;
`endif

endmodule
